adder_inverse_serial: RTL and testbench

//   Inverse of the 4-bit adder: given a sum and one addend, recovers the other addend (a = sum - b).

---
 rtl/adder_inverse_serial.sv | 126 ++++++++++++
 tb/tb_adder_inverse_serial.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_inverse_serial.sv
// Recovers the unknown addend a = sum - b with a bit-serial subtractor, LSB first,
// behind valid/ready handshakes; flags sums no in-range addend pair can produce.
module adder_inverse_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   sum_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a_o,
  output logic             err_o,
  output logic             busy_o
);

  localparam int KW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [WIDTH:0] s_reg;
  logic [WIDTH:0] b_reg;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] diff_nxt;
  logic           br;
  logic           br_nxt;
  logic           d_bit;
  logic [KW-1:0]  k;
  logic           accept;
  logic           last;
  logic           release_res;

  // One full-subtractor step: returns {borrow_out, difference_bit}.
  function automatic logic [1:0] sub_bit(input logic s, input logic b, input logic bin);
    logic d;
    logic bout;
    d    = s ^ b ^ bin;
    bout = (~s & b) | (~(s ^ b) & bin);
    return {bout, d};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    last        = 1'b0;
    release_res = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (k == KW'(WIDTH)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          release_res = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);
  assign busy_o   = (state != IDLE);

  always_comb begin
    {br_nxt, d_bit} = sub_bit(s_reg[k], b_reg[k], br);
    diff_nxt        = diff;
    diff_nxt[k]     = d_bit;
  end

  // Stage boundary: serial bit step and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg     <= '0;
      b_reg     <= '0;
      diff      <= '0;
      br        <= 1'b0;
      k         <= '0;
      a_o       <= '0;
      err_o     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        s_reg <= sum_i;
        b_reg <= {1'b0, b_i};
        diff  <= '0;
        br    <= 1'b0;
        k     <= '0;
      end else if (state == RUN) begin
        diff <= diff_nxt;
        br   <= br_nxt;
        k    <= k + KW'(1);
      end
      // A set top difference bit means a >= 2^WIDTH; a final borrow means sum < b.
      if (last) begin
        a_o       <= diff_nxt[WIDTH-1:0];
        err_o     <= diff_nxt[WIDTH] | br_nxt;
        out_valid <= 1'b1;
      end else if (release_res) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adder_inverse_serial.sv
// Bench for adder_inverse_serial: directed vector table, backpressure and reset
// sequences, exhaustive sweep and randomized operands against an arithmetic model.
module tb_adder_inverse_serial;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] sum_i;
  logic [3:0] b_i;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] a_o;
  logic       err_o;
  logic       busy_o;

  int checks   = 0;
  int failures = 0;

  adder_inverse_serial #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sum_i    (sum_i),
    .b_i      (b_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .a_o      (a_o),
    .err_o    (err_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [4:0] sum;
    logic [3:0] b;
    logic [3:0] a;
    logic       err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic void model(input int s, input int b, output logic [3:0] a, output logic e);
    int d;
    d = s - b;
    a = 4'(d & 15);
    e = (s < b) || (d > 15);
  endfunction

  // Sends one operand pair, holds out_ready low for 'hold' cycles after the result
  // appears, and returns the result along with the observed latency in edges.
  task automatic do_op(input int s, input int b, input int hold, input string tag,
                       output logic [3:0] a, output logic e);
    int n;
    int lat;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_wait"}, 32'(in_ready), 32'd1);
    sum_i     = 5'(s);
    b_i       = 4'(b);
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) check({tag, "_busy_run"}, {30'd0, busy_o, in_ready}, 32'd2);
    end while (!out_valid && lat < 20);
    check({tag, "_latency"}, 32'(lat), 32'd5);
    a = a_o;
    e = err_o;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold"}, {26'd0, out_valid, in_ready, err_o, a_o}, {26'd0, 1'b1, 1'b0, e, a});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_idle_after"}, {29'd0, out_valid, in_ready, busy_o}, 32'd2);
  endtask

  initial begin
    logic [3:0] a;
    logic       e;
    logic [3:0] ma;
    logic       me;
    int         n;
    int         rs;
    int         rb;

    vecs[0] = '{5'd12, 4'd5,  4'd7,  1'b0};
    vecs[1] = '{5'd30, 4'd15, 4'd15, 1'b0};
    vecs[2] = '{5'd31, 4'd15, 4'd0,  1'b1};
    vecs[3] = '{5'd0,  4'd0,  4'd0,  1'b0};
    vecs[4] = '{5'd3,  4'd9,  4'd10, 1'b1};
    vecs[5] = '{5'd20, 4'd4,  4'd0,  1'b1};
    vecs[6] = '{5'd18, 4'd4,  4'd14, 1'b0};
    vecs[7] = '{5'd16, 4'd0,  4'd0,  1'b1};
    vecs[8] = '{5'd15, 4'd15, 4'd0,  1'b0};
    vecs[9] = '{5'd0,  4'd15, 4'd1,  1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sum_i     = '0;
    b_i       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_a", 32'(a_o), 32'd0);
    check("reset_err", 32'(err_o), 32'd0);

    for (int i = 0; i < 10; i++) begin
      do_op(int'(vecs[i].sum), int'(vecs[i].b), 0, $sformatf("vec%0d", i), a, e);
      check($sformatf("vec%0d_a", i), 32'(a), 32'(vecs[i].a));
      check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].err));
    end

    // Backpressure: result held for 10 cycles while a second operand is offered.
    @(negedge clk);
    sum_i     = 5'd25;
    b_i       = 4'd6;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp_latency", 32'(n), 32'd5);
    check("bp_a", 32'(a_o), 32'd3);
    check("bp_err", 32'(err_o), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      sum_i    = 5'd9;
      b_i      = 4'd2;
      @(posedge clk);
      #1;
      check("bp_hold", {25'd0, out_valid, in_ready, err_o, a_o}, {25'd0, 1'b1, 1'b0, 1'b1, 4'd3});
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_handshake", {29'd0, out_valid, in_ready, busy_o}, 32'd2);
    repeat (2) @(posedge clk);
    #1;
    check("bp_not_taken", {30'd0, busy_o, out_valid}, 32'd0);
    do_op(9, 2, 0, "bp_second", a, e);
    check("bp_second_a", 32'(a), 32'd7);
    check("bp_second_err", 32'(e), 32'd0);

    // Reset after two RUN edges discards the partial result.
    @(negedge clk);
    sum_i     = 5'd20;
    b_i       = 4'd4;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outputs", {27'd0, in_ready, out_valid, busy_o, err_o, a_o != 4'd0},
          {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    check("midrst_a", 32'(a_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(20, 4, 0, "post_rst1", a, e);
    check("post_rst1_a", 32'(a), 32'd0);
    check("post_rst1_err", 32'(e), 32'd1);
    do_op(18, 4, 0, "post_rst2", a, e);
    check("post_rst2_a", 32'(a), 32'd14);
    check("post_rst2_err", 32'(e), 32'd0);

    for (int s = 0; s < 32; s++) begin
      for (int b = 0; b < 16; b++) begin
        do_op(s, b, 0, "sweep", a, e);
        model(s, b, ma, me);
        check($sformatf("sweep_a_s%0d_b%0d", s, b), 32'(a), 32'(ma));
        check($sformatf("sweep_err_s%0d_b%0d", s, b), 32'(e), 32'(me));
      end
    end

    for (int i = 0; i < 150; i++) begin
      rs = int'($urandom_range(31, 0));
      rb = int'($urandom_range(15, 0));
      do_op(rs, rb, int'($urandom_range(3, 0)), "rand", a, e);
      model(rs, rb, ma, me);
      check($sformatf("rand_a_s%0d_b%0d", rs, rb), 32'(a), 32'(ma));
      check($sformatf("rand_err_s%0d_b%0d", rs, rb), 32'(e), 32'(me));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
